// File: rtl/pid_pkg.sv
// Shared types and width helpers for the velocity-form PID controller.
package pid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_UPD
  } pid_state_e;

  typedef enum logic [2:0] {
    MAC_HOLD,
    MAC_CLR,
    MAC_LOAD,
    MAC_ADD,
    MAC_SUB
  } mac_op_e;

  localparam logic [1:0] SAT_NONE = 2'b00;
  localparam logic [1:0] SAT_LOW  = 2'b01;
  localparam logic [1:0] SAT_HIGH = 2'b10;

  // Signed error: one extra bit so sp - meas never wraps.
  function automatic int unsigned err_w(input int unsigned dw);
    return dw + 1;
  endfunction

  // a0 = kp+ki+kd needs two growth bits over the gain width.
  function automatic int unsigned coef_w(input int unsigned gw);
    return gw + 2;
  endfunction

  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned gw);
    return dw + gw + 6;
  endfunction

  // Width of pwm + increment with headroom for both clamp comparisons.
  function automatic int unsigned sum_w(input int unsigned aw, input int unsigned ow);
    return ((aw > ow) ? aw : ow) + 2;
  endfunction

endpackage

// File: rtl/pid_velocity_ctrl_if.sv
// Control/status bundle between the sample source and the PID controller.
interface pid_velocity_ctrl_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned GW = 8,
  parameter int unsigned OW = 8
);
  logic          en;
  logic          sample_stb;
  logic [DW-1:0] set_point;
  logic [DW-1:0] meas;
  logic [GW-1:0] kp;
  logic [GW-1:0] ki;
  logic [GW-1:0] kd;
  logic [OW-1:0] pwm_out;
  logic          out_valid;
  logic          busy;
  logic [1:0]    sat;
  logic          overrun;

  modport master (
    output en, sample_stb, set_point, meas, kp, ki, kd,
    input  pwm_out, out_valid, busy, sat, overrun
  );

  modport slave (
    input  en, sample_stb, set_point, meas, kp, ki, kd,
    output pwm_out, out_valid, busy, sat, overrun
  );
endinterface

// File: rtl/pid_mac.sv
// Signed multiply-accumulate: one multiplier shared across the three PID terms.
module pid_mac
  import pid_pkg::*;
#(
  parameter int unsigned CW = 10,
  parameter int unsigned EW = 9,
  parameter int unsigned AW = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  mac_op_e              op,
  input  logic [CW-1:0]        coef,
  input  logic signed [EW-1:0] err,
  output logic signed [AW-1:0] acc
);

  localparam int unsigned PW = CW + 1 + EW;

  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] prod_ext_c;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] acc_q;

  // Coefficients are unsigned; a zero MSB makes the product signed-correct.
  assign prod_c     = $signed({1'b0, coef}) * err;
  assign prod_ext_c = {{(AW-PW){prod_c[PW-1]}}, prod_c};

  always_comb begin
    acc_d = acc_q;
    case (op)
      MAC_CLR:  acc_d = '0;
      MAC_LOAD: acc_d = prod_ext_c;
      MAC_ADD:  acc_d = acc_q + prod_ext_c;
      MAC_SUB:  acc_d = acc_q - prod_ext_c;
      default:  acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/pid_velocity_ctrl.sv
// Incremental PID: u += a0*e0 - a1*e1 + a2*e2, scaled, added to the held duty and clamped.
module pid_velocity_ctrl
  import pid_pkg::*;
#(
  parameter int unsigned DW           = 8,
  parameter int unsigned GW           = 8,
  parameter int unsigned FRAC         = 0,
  parameter int unsigned OW           = 8,
  parameter int          OUT_MIN      = 0,
  parameter int          OUT_MAX      = 2**OW - 1,
  parameter bit          HOLD_ZERO_SP = 1'b1
) (
  input logic                CLK,
  input logic                RST,
  pid_velocity_ctrl_if.slave bus
);

  localparam int unsigned EW = err_w(DW);
  localparam int unsigned CW = coef_w(GW);
  localparam int unsigned AW = acc_w(DW, GW);
  localparam int unsigned UW = sum_w(AW, OW);

  localparam logic [OW-1:0]        OUT_MIN_V = OW'(OUT_MIN);
  localparam logic [OW-1:0]        OUT_MAX_V = OW'(OUT_MAX);
  localparam logic signed [UW-1:0] OUT_MIN_S = UW'(OUT_MIN);
  localparam logic signed [UW-1:0] OUT_MAX_S = UW'(OUT_MAX);

  pid_state_e           state_q, state_d;
  logic [DW-1:0]        held_sp_q, held_sp_d;
  logic signed [EW-1:0] e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic [CW-1:0]        a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
  logic [OW-1:0]        pwm_q, pwm_d;
  logic [1:0]           sat_q, sat_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic [DW-1:0]        sp_eff_c;
  logic signed [EW-1:0] err_new_c;
  mac_op_e              mac_op_c;
  logic [CW-1:0]        mac_coef_c;
  logic signed [EW-1:0] mac_err_c;
  logic signed [AW-1:0] acc_c;
  logic signed [AW-1:0] d_c;
  logic signed [UW-1:0] u_c;

  // A zero set point is treated as "keep the last commanded speed".
  assign sp_eff_c  = (HOLD_ZERO_SP && (bus.set_point == '0)) ? held_sp_q : bus.set_point;
  assign err_new_c = $signed({1'b0, sp_eff_c}) - $signed({1'b0, bus.meas});

  assign d_c = acc_c >>> FRAC;
  assign u_c = $signed({{(UW-AW){d_c[AW-1]}}, d_c}) + $signed({{(UW-OW){1'b0}}, pwm_q});

  pid_mac #(
    .CW (CW),
    .EW (EW),
    .AW (AW)
  ) u_mac (
    .clk   (CLK),
    .rst_n (RST),
    .op    (mac_op_c),
    .coef  (mac_coef_c),
    .err   (mac_err_c),
    .acc   (acc_c)
  );

  always_comb begin
    state_d     = state_q;
    held_sp_d   = held_sp_q;
    e0_d        = e0_q;
    e1_d        = e1_q;
    e2_d        = e2_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    pwm_d       = pwm_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    overrun_d   = overrun_q;
    mac_op_c    = MAC_HOLD;
    mac_coef_c  = '0;
    mac_err_c   = '0;

    if (!bus.en) begin
      state_d   = ST_IDLE;
      e0_d      = '0;
      e1_d      = '0;
      e2_d      = '0;
      pwm_d     = OUT_MIN_V;
      sat_d     = SAT_NONE;
      overrun_d = 1'b0;
      mac_op_c  = MAC_CLR;
    end else begin
      // Any strobe outside IDLE is dropped and flagged.
      if (bus.sample_stb && (state_q != ST_IDLE)) overrun_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.sample_stb) state_d = ST_CAPT;
        end
        ST_CAPT: begin
          held_sp_d = sp_eff_c;
          e2_d      = e1_q;
          e1_d      = e0_q;
          e0_d      = err_new_c;
          a0_d      = CW'(bus.kp) + CW'(bus.ki) + CW'(bus.kd);
          a1_d      = CW'(bus.kp) + (CW'(bus.kd) << 1);
          a2_d      = CW'(bus.kd);
          state_d   = ST_M0;
        end
        ST_M0: begin
          mac_op_c   = MAC_LOAD;
          mac_coef_c = a0_q;
          mac_err_c  = e0_q;
          state_d    = ST_M1;
        end
        ST_M1: begin
          mac_op_c   = MAC_SUB;
          mac_coef_c = a1_q;
          mac_err_c  = e1_q;
          state_d    = ST_M2;
        end
        ST_M2: begin
          mac_op_c   = MAC_ADD;
          mac_coef_c = a2_q;
          mac_err_c  = e2_q;
          state_d    = ST_UPD;
        end
        ST_UPD: begin
          if (u_c > OUT_MAX_S) begin
            pwm_d = OUT_MAX_V;
            sat_d = SAT_HIGH;
          end else if (u_c < OUT_MIN_S) begin
            pwm_d = OUT_MIN_V;
            sat_d = SAT_LOW;
          end else begin
            pwm_d = OW'(u_c);
            sat_d = SAT_NONE;
          end
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      busy_d = state_d inside {ST_M0, ST_M1, ST_M2, ST_UPD};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      held_sp_q   <= '0;
      e0_q        <= '0;
      e1_q        <= '0;
      e2_q        <= '0;
      a0_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      pwm_q       <= OUT_MIN_V;
      sat_q       <= SAT_NONE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_sp_q   <= held_sp_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      pwm_q       <= pwm_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.pwm_out   = pwm_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sat       = sat_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pid_velocity_ctrl.sv
// Bench for pid_velocity_ctrl: two instances (FRAC=0 and FRAC=1) against a latency-level model.
module tb_pid_velocity_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pid_velocity_ctrl_if #(.DW(8), .GW(8), .OW(8)) bus_a ();
  pid_velocity_ctrl_if #(.DW(8), .GW(8), .OW(8)) bus_b ();

  pid_velocity_ctrl #(.DW(8), .GW(8), .FRAC(0), .OW(8), .OUT_MIN(0), .OUT_MAX(255), .HOLD_ZERO_SP(1'b1))
    dut_a (.CLK(clk), .RST(rst_n), .bus(bus_a));
  pid_velocity_ctrl #(.DW(8), .GW(8), .FRAC(1), .OW(8), .OUT_MIN(0), .OUT_MAX(255), .HOLD_ZERO_SP(1'b1))
    dut_b (.CLK(clk), .RST(rst_n), .bus(bus_b));

  logic       en_i  [2];
  logic       stb_i [2];
  logic [7:0] sp_i  [2];
  logic [7:0] meas_i[2];
  logic [7:0] kp_i  [2];
  logic [7:0] ki_i  [2];
  logic [7:0] kd_i  [2];

  assign bus_a.en = en_i[0];  assign bus_a.sample_stb = stb_i[0];
  assign bus_a.set_point = sp_i[0];  assign bus_a.meas = meas_i[0];
  assign bus_a.kp = kp_i[0];  assign bus_a.ki = ki_i[0];  assign bus_a.kd = kd_i[0];
  assign bus_b.en = en_i[1];  assign bus_b.sample_stb = stb_i[1];
  assign bus_b.set_point = sp_i[1];  assign bus_b.meas = meas_i[1];
  assign bus_b.kp = kp_i[1];  assign bus_b.ki = ki_i[1];  assign bus_b.kd = kd_i[1];

  logic [7:0] pwm_o  [2];
  logic [1:0] sat_o  [2];
  logic       valid_o[2];
  logic       busy_o [2];
  logic       ovr_o  [2];

  assign pwm_o[0] = bus_a.pwm_out;  assign sat_o[0] = bus_a.sat;  assign valid_o[0] = bus_a.out_valid;
  assign busy_o[0] = bus_a.busy;    assign ovr_o[0] = bus_a.overrun;
  assign pwm_o[1] = bus_b.pwm_out;  assign sat_o[1] = bus_b.sat;  assign valid_o[1] = bus_b.out_valid;
  assign busy_o[1] = bus_b.busy;    assign ovr_o[1] = bus_b.overrun;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: per-instance state after the most recent clock edge.
  int m_pwm[2], m_sat[2], m_valid[2], m_busy[2], m_ovr[2];
  int m_cnt[2], m_held[2], m_npwm[2], m_nsat[2];
  int m_e0[2], m_e1[2], m_e2[2];

  task automatic model_reset(input int i);
    m_pwm[i] = 0; m_sat[i] = 0; m_valid[i] = 0; m_busy[i] = 0; m_ovr[i] = 0;
    m_cnt[i] = 0; m_held[i] = 0; m_npwm[i] = 0; m_nsat[i] = 0;
    m_e0[i] = 0;  m_e1[i] = 0;  m_e2[i] = 0;
  endtask

  // Predicts the outputs after the next rising edge from the inputs now applied.
  task automatic model_step(input int i);
    int sp, acc, d, u, kp, ki, kd;
    if (!en_i[i]) begin
      m_cnt[i] = 0; m_e0[i] = 0; m_e1[i] = 0; m_e2[i] = 0;
      m_pwm[i] = 0; m_sat[i] = 0; m_ovr[i] = 0; m_valid[i] = 0;
    end else begin
      m_valid[i] = 0;
      if (m_cnt[i] > 0) begin
        if (stb_i[i]) m_ovr[i] = 1;
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_pwm[i] = m_npwm[i]; m_sat[i] = m_nsat[i]; m_valid[i] = 1;
        end
      end else if (stb_i[i]) begin
        sp = int'(sp_i[i]);
        if (sp == 0) sp = m_held[i];
        else m_held[i] = sp;
        m_e2[i] = m_e1[i];
        m_e1[i] = m_e0[i];
        m_e0[i] = sp - int'(meas_i[i]);
        kp = int'(kp_i[i]); ki = int'(ki_i[i]); kd = int'(kd_i[i]);
        acc = (kp + ki + kd) * m_e0[i] - (kp + 2 * kd) * m_e1[i] + kd * m_e2[i];
        d = acc >>> ((i == 0) ? 0 : 1);
        u = m_pwm[i] + d;
        if (u > 255)    begin m_npwm[i] = 255; m_nsat[i] = 2; end
        else if (u < 0) begin m_npwm[i] = 0;   m_nsat[i] = 1; end
        else            begin m_npwm[i] = u;   m_nsat[i] = 0; end
        m_cnt[i] = 5;
      end
    end
    m_busy[i] = (m_cnt[i] >= 1 && m_cnt[i] <= 4) ? 1 : 0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) model_reset(i);
        check($sformatf("cmp%0d.pwm", i),   int'(pwm_o[i]),   m_pwm[i]);
        check($sformatf("cmp%0d.sat", i),   int'(sat_o[i]),   m_sat[i]);
        check($sformatf("cmp%0d.valid", i), int'(valid_o[i]), m_valid[i]);
        check($sformatf("cmp%0d.busy", i),  int'(busy_o[i]),  m_busy[i]);
        check($sformatf("cmp%0d.ovr", i),   int'(ovr_o[i]),   m_ovr[i]);
        if (rst_n) model_step(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input int sp, input int m);
    sp_i[i] = 8'(sp); meas_i[i] = 8'(m); stb_i[i] = 1'b1;
    tick();
    stb_i[i] = 1'b0;
  endtask

  task automatic expect_update(input int i, input string name, input int exp_pwm, input int exp_sat);
    int n = 0;
    while (!valid_o[i] && n < 12) begin
      tick();
      n++;
    end
    check({name, ".lat"}, n, 5);
    check({name, ".pwm"}, int'(pwm_o[i]), exp_pwm);
    check({name, ".sat"}, int'(sat_o[i]), exp_sat);
  endtask

  task automatic clear_hist(input int i);
    en_i[i] = 1'b0;
    tick();
    check($sformatf("clr%0d.pwm", i), int'(pwm_o[i]), 0);
    en_i[i] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    for (int i = 0; i < 2; i++) begin
      en_i[i] = 1'b0; stb_i[i] = 1'b0; sp_i[i] = '0; meas_i[i] = '0;
      kp_i[i] = '0;   ki_i[i] = '0;    kd_i[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst.pwm",  int'(pwm_o[0]), 0);
    check("rst.busy", int'(busy_o[0]), 0);
    check("rst.sat",  int'(sat_o[0]), 0);
    check("rst.ovr",  int'(ovr_o[0]), 0);
    rst_n = 1'b1;
    tick();

    // FRAC=1 instance: ki=2 halves back to a unit integrator.
    en_i[1] = 1'b1; ki_i[1] = 8'd2;
    strobe(1, 50, 45); expect_update(1, "frac1_s1", 5, 0);
    strobe(1, 50, 45); expect_update(1, "frac1_s2", 10, 0);
    strobe(1, 50, 45); expect_update(1, "frac1_s3", 15, 0);

    en_i[0] = 1'b1; kp_i[0] = 8'd1;
    strobe(0, 100, 0);  expect_update(0, "p_step", 100, 0);
    strobe(0, 100, 40); expect_update(0, "p_meas40", 60, 0);

    clear_hist(0); kp_i[0] = 8'd2;
    strobe(0, 255, 0); expect_update(0, "p2_high", 255, 2);
    strobe(0, 0, 255); expect_update(0, "p2_holdsp", 0, 1);

    clear_hist(0); kp_i[0] = 8'd0; ki_i[0] = 8'd1;
    strobe(0, 50, 45); expect_update(0, "i_s1", 5, 0);
    strobe(0, 50, 45); expect_update(0, "i_s2", 10, 0);
    strobe(0, 50, 45); expect_update(0, "i_s3", 15, 0);

    clear_hist(0); ki_i[0] = 8'd0; kd_i[0] = 8'd1;
    strobe(0, 10, 0); expect_update(0, "d_s1", 10, 0);
    strobe(0, 20, 0); expect_update(0, "d_s2", 10, 0);
    strobe(0, 5, 0);  expect_update(0, "d_s3", 0, 1);

    // Second strobe lands two edges after the first.
    clear_hist(0); kd_i[0] = 8'd0; kp_i[0] = 8'd1;
    strobe(0, 100, 0);
    tick();
    strobe(0, 50, 0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid_o[0]) pulses++;
      tick();
    end
    check("ovr.pulses", pulses, 1);
    check("ovr.pwm", int'(pwm_o[0]), 100);
    check("ovr.flag", int'(ovr_o[0]), 1);
    en_i[0] = 1'b0;
    tick();
    check("enlow.pwm",  int'(pwm_o[0]), 0);
    check("enlow.ovr",  int'(ovr_o[0]), 0);
    check("enlow.busy", int'(busy_o[0]), 0);
    en_i[0] = 1'b1;
    strobe(0, 0, 0); expect_update(0, "held_kept", 100, 0);

    // Async reset while the MAC is in its subtract step.
    strobe(0, 100, 0);
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.pwm",   int'(pwm_o[0]), 0);
    check("arst.busy",  int'(busy_o[0]), 0);
    check("arst.valid", int'(valid_o[0]), 0);
    check("arst.sat",   int'(sat_o[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    strobe(0, 100, 0); expect_update(0, "post_rst", 100, 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
